mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset; synchronous and active-low.
REQ-003 SHALL have ports opcode (input, 7 bits), func3 (input, 3 bits) and func7 (input, 7 bits), taken from the instruction register.
REQ-004 SHALL have ports zero, lt and bge, each input, 1 bit: datapath compare flags for rs1 versus rs2.
REQ-005 SHALL have port mem_ready, input, 1 bit: the unified memory has completed the current access.
REQ-006 SHALL have outputs PCWrite, IRWrite, AdrSrc, MemWrite and RegWrite, each 1 bit, with the usual datapath strobe meanings.
REQ-007 SHALL have outputs ResultSrc (2 bits), ALUSrcA (2 bits) and ALUSrcB (2 bits), which select datapath mux inputs.
REQ-008 SHALL have outputs ALUControl (3 bits) and ImmSrc (3 bits).
REQ-009 SHALL have output illegal, 1 bit: a one-cycle pulse on an unsupported opcode or function code.

Function
REQ-010 SHALL use these encodings.
- ALUControl: add=000, sub=001, and=010, or=011, xor=100, slt=101, sltu=110.
- ImmSrc: I=000, S=001, B=010, U=011, J=100.
- ResultSrc: ALUOut=00, ReadData=01, ALUResult=10, ImmExt=11.
- ALUSrcA: PC=00, OldPC=01, rs1=10.
- ALUSrcB: rs2=00, imm=01, const4=10.
REQ-011 SHALL be a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR_ADR, JALR_PC, LUI.
REQ-012 SHALL drive every output not explicitly listed for a state to 0. The only exceptions are PCWrite in BRANCH and the mem_ready-gated strobes.
REQ-013 FETCH: drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10 and add. Assert IRWrite=PCWrite=1 only when mem_ready=1, then go to DECODE; otherwise hold in FETCH.
REQ-014 DECODE: drive ALUSrcA=01, ALUSrcB=01, ImmSrc=B and add, which forms the branch/jal target. Next state by opcode:
- 3 or 35 -> MEMADR
- 51 -> EXECR
- 19 -> EXECI
- 99 -> BRANCH
- 111 -> JAL
- 103 -> JALR_ADR
- 55 -> LUI
- any other opcode -> FETCH with illegal=1
REQ-015 MEMADR: drive ALUSrcA=10, ALUSrcB=01 and add. Use ImmSrc=I when opcode=3 (next MEMREAD) and ImmSrc=S when opcode=35 (next MEMWRITE).
REQ-016 MEMREAD: drive AdrSrc=1 and ResultSrc=00. Hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWB: drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-018 MEMWRITE: drive AdrSrc=1, ResultSrc=00 and MemWrite=1. Hold while mem_ready=0; go to FETCH in the cycle mem_ready=1.
REQ-019 EXECR: drive ALUSrcA=10 and ALUSrcB=00, then go to ALUWB. Decode {func7,func3}:
- 0 -> add
- 256 -> sub
- 6 -> or
- 7 -> and
- 2 -> slt
- 3 -> sltu
- other -> illegal=1, next FETCH
REQ-020 EXECI: drive ALUSrcA=10, ALUSrcB=01 and ImmSrc=I, then go to ALUWB. Decode func3:
- 000 -> add
- 100 -> xor
- 110 -> or
- 010 -> slt
- 011 -> sltu
- other -> illegal=1, next FETCH
REQ-021 ALUWB: drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-022 BRANCH: drive ALUSrcA=10, ALUSrcB=00, sub and ResultSrc=00, then go to FETCH. PCWrite is:
- zero for beq (func3=000)
- !zero for bne (001)
- lt for blt (100)
- bge for bge (101)
- other func3 -> PCWrite=0, illegal=1
REQ-023 JAL: drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 and PCWrite=1, then go to ALUWB (writes OldPC+4).
REQ-024 JALR_ADR: drive ALUSrcA=10, ALUSrcB=01, ImmSrc=I and add, then go to JALR_PC.
REQ-025 JALR_PC: drive ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10 and add, then go to ALUWB.
REQ-026 LUI: drive ImmSrc=U, ResultSrc=11 and RegWrite=1, then go to FETCH.
REQ-027 SHALL have these instruction latencies, with mem_ready=1 throughout:
- R/I/jal: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- branch: 3 cycles
- jalr: 5 cycles
- lui: 3 cycles
- illegal: 2 cycles
REQ-028 SHALL extend each latency by one cycle for every cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE. mem_ready SHALL be ignored in all other states.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, go to FETCH in the next cycle regardless of current state, aborting any in-progress access.
REQ-030 SHALL drive illegal=0 and MemWrite=RegWrite=0 while rst_n=0; other outputs carry their FETCH values.

Structure
REQ-031 SHALL place the state enum, opcode constants and the ALUControl/ImmSrc/ResultSrc/ALUSrc encodings in shared package riscv_pkg.
REQ-032 SHALL split the ALU decode of REQ-019/REQ-020 into one combinational sub-module, alu_decoder, instanced by mc_controller.

Verification
REQ-033 After reset, add x3,x1,x2 with mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; ALUControl=000 in EXECR.
REQ-034 lw with mem_ready held low 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles; RegWrite with ResultSrc=01 follows one cycle later; total 7 cycles.
REQ-035 beq with zero=1, then with zero=0 -> BRANCH PCWrite=1, then 0; ALUControl=001 both times; back in FETCH next cycle.
REQ-036 jal, then jalr -> PCWrite in JAL / JALR_PC; RegWrite in the following ALUWB with ResultSrc=00.
REQ-037 opcode=7'h7F, then opcode=51 with {func7,func3}=10'd5 -> illegal pulses 1 cycle each; no RegWrite or MemWrite; returns to FETCH.
REQ-038 rst_n=0 during MEMWRITE with mem_ready=0 -> MemWrite drops; state is FETCH the cycle after rst_n returns high.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared FSM states, opcodes and datapath select encodings for the multicycle controller
package riscv_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR_ADR, JALR_PC, LUI
  } state_t;
  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_IMM    = 2'b11;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps R-type {func7,func3} or I-type func3 to an ALU operation and flags unsupported codes
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  input  logic       rtype_i,
  output logic [2:0] alu_ctl_o,
  output logic       bad_o
);
  logic [9:0] key;
  assign key = {func7_i, func3_i};
  // R-type needs the full function code; I-type only func3
  always_comb begin
    alu_ctl_o = ALU_ADD;
    bad_o = 1'b0;
    if (rtype_i)
      case (key)
        10'd0:   alu_ctl_o = ALU_ADD;
        10'd256: alu_ctl_o = ALU_SUB;
        10'd6:   alu_ctl_o = ALU_OR;
        10'd7:   alu_ctl_o = ALU_AND;
        10'd2:   alu_ctl_o = ALU_SLT;
        10'd3:   alu_ctl_o = ALU_SLTU;
        default: bad_o = 1'b1;
      endcase
    else
      case (func3_i)
        3'b000:  alu_ctl_o = ALU_ADD;
        3'b100:  alu_ctl_o = ALU_XOR;
        3'b110:  alu_ctl_o = ALU_OR;
        3'b010:  alu_ctl_o = ALU_SLT;
        3'b011:  alu_ctl_o = ALU_SLTU;
        default: bad_o = 1'b1;
      endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing a multicycle RISC-V datapath over a unified memory
module mc_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  input  logic       bge,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal
);
  state_t state_q, state_d, st;
  logic [2:0] dec_alu;
  logic dec_bad;
  // while reset is asserted the outputs decode as FETCH, which also silences writes and illegal
  assign st = rst_n ? state_q : FETCH;
  alu_decoder u_alu_decoder (
    .func3_i(func3),
    .func7_i(func7),
    .rtype_i(st == EXECR),
    .alu_ctl_o(dec_alu),
    .bad_o(dec_bad)
  );
  // state register with synchronous active-low reset
  always_ff @(posedge clk) state_q <= rst_n ? state_d : FETCH;
  // next state and per-state strobes; everything not set below stays 0
  always_comb begin
    state_d = FETCH;
    PCWrite = 1'b0;
    IRWrite = 1'b0;
    AdrSrc = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_RS2;
    ALUControl = ALU_ADD;
    ImmSrc = IMM_I;
    illegal = 1'b0;
    case (st)
      FETCH: begin
        ALUSrcB = SRCB_4;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:    state_d = EXECR;
          OP_I:    state_d = EXECI;
          OP_BR:   state_d = BRANCH;
          OP_JAL:  state_d = JAL;
          OP_JALR: state_d = JALR_ADR;
          OP_LUI:  state_d = LUI;
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc = opcode == OP_STORE ? IMM_S : IMM_I;
        state_d = opcode == OP_STORE ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = RES_READ;
        RegWrite = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemWrite = 1'b1;
        state_d = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR, EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = st == EXECI ? SRCB_IMM : SRCB_RS2;
        ALUControl = dec_alu;
        illegal = dec_bad;
        state_d = dec_bad ? FETCH : ALUWB;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUControl = ALU_SUB;
        PCWrite = func3 == 3'b000 ? zero : func3 == 3'b001 ? !zero :
                  func3 == 3'b100 ? lt : func3 == 3'b101 ? bge : 1'b0;
        illegal = !(func3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      end
      JAL, JALR_PC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      JALR_ADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = JALR_PC;
      end
      LUI: begin
        ImmSrc = IMM_U;
        ResultSrc = RES_IMM;
        RegWrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed cycle-by-cycle checks of mc_controller output vectors
module tb_mc_controller;
  logic clk = 1'b0;
  logic rst_n, zero, lt, bge, mem_ready;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  int n_vec = 0;
  int n_err = 0;
  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .bge(bge), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
  );
  always #5 clk = ~clk;
  logic [17:0] outv;
  assign outv = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, illegal};
  function automatic logic [17:0] o(input logic pc, ir, adr, mw, rw, input logic [1:0] res,
                                    sa, sb, input logic [2:0] alu, imm, input logic ill);
    return {pc, ir, adr, mw, rw, res, sa, sb, alu, imm, ill};
  endfunction
  function automatic logic [17:0] f1();        return o(1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0); endfunction
  function automatic logic [17:0] f0();        return o(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0); endfunction
  function automatic logic [17:0] dec(input logic ill); return o(0, 0, 0, 0, 0, 0, 1, 1, 0, 2, ill); endfunction
  function automatic logic [17:0] exr(input logic [2:0] a, input logic ill); return o(0, 0, 0, 0, 0, 0, 2, 0, a, 0, ill); endfunction
  function automatic logic [17:0] exi(input logic [2:0] a); return o(0, 0, 0, 0, 0, 0, 2, 1, a, 0, 0); endfunction
  function automatic logic [17:0] aluwb();     return o(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [17:0] madr(input logic s); return o(0, 0, 0, 0, 0, 0, 2, 1, 0, {2'b0, s}, 0); endfunction
  function automatic logic [17:0] mrd();       return o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [17:0] mwb();       return o(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); endfunction
  function automatic logic [17:0] mwr();       return o(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [17:0] br(input logic pc, ill); return o(pc, 0, 0, 0, 0, 0, 2, 0, 1, 0, ill); endfunction
  function automatic logic [17:0] jpc();       return o(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0); endfunction
  function automatic logic [17:0] lui();       return o(0, 0, 0, 0, 1, 3, 0, 0, 0, 3, 0); endfunction
  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [17:0] exp);
    @(negedge clk);
    chk(tag, outv, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    func3 = f3;
    func7 = f7;
  endtask
  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; bge = 1'b0;
    ins(7'd0, 3'd0, 7'd0);
    step("rst0", f0());
    step("rst1", f0());
    rst_n = 1'b1; mem_ready = 1'b1;
    ins(7'd51, 3'd0, 7'd0);
    step("add_f", f1()); step("add_d", dec(0)); step("add_x", exr(3'b000, 0)); step("add_wb", aluwb());
    ins(7'd51, 3'd0, 7'd32);
    step("sub_f", f1()); step("sub_d", dec(0)); step("sub_x", exr(3'b001, 0)); step("sub_wb", aluwb());
    ins(7'd51, 3'd7, 7'd0);
    step("and_f", f1()); step("and_d", dec(0)); step("and_x", exr(3'b010, 0)); step("and_wb", aluwb());
    ins(7'd51, 3'd3, 7'd0);
    step("sltu_f", f1());
    mem_ready = 1'b0;
    step("sltu_d", dec(0)); step("sltu_x", exr(3'b110, 0)); step("sltu_wb", aluwb());
    mem_ready = 1'b1;
    ins(7'd19, 3'd4, 7'd0);
    step("xori_f", f1()); step("xori_d", dec(0)); step("xori_x", exi(3'b100)); step("xori_wb", aluwb());
    ins(7'd19, 3'd2, 7'd0);
    step("slti_f", f1()); step("slti_d", dec(0)); step("slti_x", exi(3'b101)); step("slti_wb", aluwb());
    ins(7'd3, 3'd2, 7'd0);
    step("lw_f", f1()); step("lw_d", dec(0)); step("lw_a", madr(0));
    mem_ready = 1'b0;
    step("lw_r0", mrd()); step("lw_r1", mrd());
    mem_ready = 1'b1;
    step("lw_r2", mrd()); step("lw_wb", mwb());
    ins(7'd35, 3'd2, 7'd0);
    step("sw_f", f1()); step("sw_d", dec(0)); step("sw_a", madr(1)); step("sw_w", mwr());
    ins(7'd99, 3'd0, 7'd0); zero = 1'b1;
    step("beq1_f", f1()); step("beq1_d", dec(0)); step("beq1_b", br(1, 0));
    zero = 1'b0;
    step("beq0_f", f1()); step("beq0_d", dec(0)); step("beq0_b", br(0, 0));
    ins(7'd99, 3'd1, 7'd0);
    step("bne_f", f1()); step("bne_d", dec(0)); step("bne_b", br(1, 0));
    ins(7'd99, 3'd4, 7'd0); lt = 1'b1;
    step("blt_f", f1()); step("blt_d", dec(0)); step("blt_b", br(1, 0));
    ins(7'd99, 3'd2, 7'd0);
    step("bbad_f", f1()); step("bbad_d", dec(0)); step("bbad_b", br(0, 1));
    ins(7'd111, 3'd0, 7'd0);
    step("jal_f", f1()); step("jal_d", dec(0)); step("jal_j", jpc()); step("jal_wb", aluwb());
    ins(7'd103, 3'd0, 7'd0);
    step("jalr_f", f1()); step("jalr_d", dec(0)); step("jalr_a", madr(0)); step("jalr_pc", jpc()); step("jalr_wb", aluwb());
    ins(7'd55, 3'd0, 7'd0);
    mem_ready = 1'b0;
    step("lui_s0", f0()); step("lui_s1", f0());
    mem_ready = 1'b1;
    step("lui_f", f1()); step("lui_d", dec(0)); step("lui_u", lui());
    ins(7'h7F, 3'd0, 7'd0);
    step("ilop_f", f1()); step("ilop_d", dec(1));
    ins(7'd51, 3'd5, 7'd0);
    step("ilr_f", f1()); step("ilr_d", dec(0)); step("ilr_x", exr(3'b000, 1));
    ins(7'd35, 3'd2, 7'd0);
    step("swr_f", f1()); step("swr_d", dec(0)); step("swr_a", madr(1));
    mem_ready = 1'b0;
    step("swr_w0", mwr()); step("swr_w1", mwr());
    rst_n = 1'b0;
    step("swr_rst", f0());
    rst_n = 1'b1; mem_ready = 1'b1;
    step("swr_f2", f1()); step("swr_d2", dec(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
